// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: word size, FSM states, FIFO entry layout.
package ifetch_pkg;

   localparam int unsigned WORDSIZE = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic [WORDSIZE-1:0] pc;
      logic [WORDSIZE-1:0] data;
      logic                err;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

   // Instructions are word aligned; any set low address bit is a fetch fault.
   function automatic logic is_misaligned(input logic [1:0] addr_lsb);
      return addr_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Fetched-instruction FIFO: DEPTH entries (power of two), synchronous flush, head always visible.
module ifetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      do_push = push & (count_q < CNT_W'(DEPTH));
      do_pop  = pop & (count_q != '0);
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = wptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign head_data = mem_q[rptr_q];
   assign count     = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory read at a time, results queued for decode.
// Define IFETCH_MISALIGN_CHK_EN to fault misaligned fetch addresses without a memory access.
module ifetch
   import ifetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                req_valid,
   input  logic [WORDSIZE-1:0] req_addr,
   output logic                req_ready,
   input  logic                flush,
   output logic                mem_req,
   output logic [WORDSIZE-1:0] mem_addr,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [WORDSIZE-1:0] mem_rdata,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [WORDSIZE-1:0] inst_data,
   output logic [WORDSIZE-1:0] inst_pc,
   output logic                inst_err
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   state_e              state_q, state_d;
   logic [WORDSIZE-1:0] addr_q, addr_d;
   logic                kill_q, kill_d;
   logic                mem_req_q, mem_req_d;
   logic                run_q;
   logic                accept;
   logic                fifo_push;
   logic                fifo_pop;
   fetch_entry_t        push_entry;
   fetch_entry_t        head_entry;
   logic [CNT_W-1:0]    fifo_count;

   // run_q holds off acceptance until the first clock edge after reset release.
   assign req_ready = run_q & (state_q == ST_IDLE) & ~flush & (fifo_count < CNT_W'(DEPTH));
   assign accept    = req_valid & req_ready;
   assign fifo_pop  = inst_valid & inst_ready;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      kill_d     = kill_q;
      fifo_push  = 1'b0;
      push_entry = '{pc: addr_q, data: '0, err: 1'b0};
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d  = req_addr;
               state_d = ST_REQ;
`ifdef IFETCH_MISALIGN_CHK_EN
               if (is_misaligned(req_addr[1:0])) begin
                  state_d    = ST_IDLE;
                  fifo_push  = 1'b1;
                  push_entry = '{pc: req_addr, data: '0, err: 1'b1};
               end
`endif
            end
         end
         ST_REQ: begin
            if (flush) kill_d = 1'b1;
            if (mem_gnt) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (flush) kill_d = 1'b1;
            // A killed or flush-coincident response is dropped; either way the transaction ends.
            if (mem_rvalid) begin
               state_d = ST_IDLE;
               kill_d  = 1'b0;
               if (!kill_q && !flush) begin
                  fifo_push  = 1'b1;
                  push_entry = '{pc: addr_q, data: mem_rdata, err: 1'b0};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      mem_req_d = (state_d == ST_REQ);
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         kill_q    <= 1'b0;
         mem_req_q <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         kill_q    <= kill_d;
         mem_req_q <= mem_req_d;
         run_q     <= 1'b1;
      end
   end

   ifetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (reset),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .flush     (flush),
      .head_data (head_entry),
      .count     (fifo_count)
   );

   assign mem_req    = mem_req_q;
   assign mem_addr   = addr_q;
   assign inst_valid = (fifo_count != '0);
   assign inst_data  = head_entry.data;
   assign inst_pc    = head_entry.pc;
   assign inst_err   = head_entry.err;

endmodule
